mem_load_unit: RTL and testbench

- Read-side counterpart of the store-side memory request preparation logic.
- Tracks outstanding load requests in issue order and stores per-load metadata: width, signedness, byte index and destination tag.
- On each in-order memory read response, extracts the addressed byte, halfword or word, then sign- or zero-extends it.
- Presents the result to writeback over a valid/ready handshake. Sits between the LSU issue point and the register-file writeback arbiter.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_load_unit_if.sv | 44 ++++
 rtl/mem_load_align.sv | 41 ++++
 rtl/mem_load_unit.sv | 98 +++++++++
 tb/tb_mem_load_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Memory access encodings and load-buffer entry layout shared by the
// load and store request paths.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Tag is held alongside in a separately sized array.
    typedef struct packed {
        logic [1:0]  width;
        logic        uns;
        logic [1:0]  idx;
        logic        done;
        logic        err;
        logic [31:0] data;
    } ld_entry_t;

endpackage

// File: rtl/mem_load_unit_if.sv
// Issue, memory response and writeback signals of the load unit.
// slave is the load unit, master is the surrounding core.
interface mem_load_unit_if #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_width_i;
    logic             req_unsigned_i;
    logic [1:0]       req_byte_idx_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;
    logic             mem_rerr_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [31:0]      wb_data_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic             wb_err_o;
    logic             spurious_o;
    logic [CW-1:0]    pending_o;

    modport master (
        output req_valid_i, req_width_i, req_unsigned_i,
        output req_byte_idx_i, req_tag_i,
        output mem_rvalid_i, mem_rdata_i, mem_rerr_i,
        output wb_ready_i,
        input  req_ready_o, wb_valid_o, wb_data_o, wb_tag_o,
        input  wb_err_o, spurious_o, pending_o
    );

    modport slave (
        input  req_valid_i, req_width_i, req_unsigned_i,
        input  req_byte_idx_i, req_tag_i,
        input  mem_rvalid_i, mem_rdata_i, mem_rerr_i,
        input  wb_ready_i,
        output req_ready_o, wb_valid_o, wb_data_o, wb_tag_o,
        output wb_err_o, spurious_o, pending_o
    );

endinterface

// File: rtl/mem_load_align.sv
// Extracts and extends the addressed byte/half/word of a read word;
// flags misalignment, illegal width and bus errors.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  width,
    input  logic        uns,
    input  logic [1:0]  idx,
    input  logic        rerr,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{idx, 3'b000} +: 8];
    assign h = rdata[{idx[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        err  = rerr;
        unique case (1'b1)
            (width == MEM_BYTE): begin
                data = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            (width == MEM_HALF): begin
                err  = rerr | idx[0];
                data = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            (width == MEM_WORD): begin
                err  = rerr | (idx != 2'b00);
                data = rdata;
            end
            default: err = 1'b1;
        endcase
        if (err) data = '0;
    end

endmodule

// File: rtl/mem_load_unit.sv
// In-order load completion buffer: tracks issued loads, aligns each
// memory response into its entry and retires results to writeback.
module mem_load_unit
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input logic      clk_i,
    input logic      rst_i,
    mem_load_unit_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    ld_entry_t        ent_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [PW-1:0] alloc_q, fill_q, pop_q;
    logic [PW-1:0] count;
    logic [AW-1:0] ai, fi, pi;
    logic          spur_q;

    logic          do_alloc, do_fill, do_pop, spur;
    logic [31:0]   al_data;
    logic          al_err;
    ld_entry_t     head;

    assign ai    = alloc_q[AW-1:0];
    assign fi    = fill_q[AW-1:0];
    assign pi    = pop_q[AW-1:0];
    assign count = alloc_q - pop_q;
    assign head  = ent_q[pi];

    // Ready depends only on registered state, never on wb_ready_i.
    assign bus.req_ready_o = (count < DEPTH_P) && !rst_i;

    assign do_alloc = bus.req_valid_i && bus.req_ready_o;
    assign do_fill  = bus.mem_rvalid_i && (alloc_q != fill_q);
    assign spur     = bus.mem_rvalid_i && (alloc_q == fill_q);
    assign do_pop   = bus.wb_valid_o && bus.wb_ready_i;

    mem_load_align u_align (
        .rdata (bus.mem_rdata_i),
        .width (ent_q[fi].width),
        .uns   (ent_q[fi].uns),
        .idx   (ent_q[fi].idx),
        .rerr  (bus.mem_rerr_i),
        .data  (al_data),
        .err   (al_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_q <= '0;
            fill_q  <= '0;
            pop_q   <= '0;
            spur_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            spur_q <= spur;
            if (do_alloc) begin
                ent_q[ai].width <= bus.req_width_i;
                ent_q[ai].uns   <= bus.req_unsigned_i;
                ent_q[ai].idx   <= bus.req_byte_idx_i;
                ent_q[ai].done  <= 1'b0;
                ent_q[ai].err   <= 1'b0;
                ent_q[ai].data  <= '0;
                tag_q[ai]       <= bus.req_tag_i;
                alloc_q         <= alloc_q + PW'(1);
            end
            if (do_fill) begin
                ent_q[fi].done <= 1'b1;
                ent_q[fi].err  <= al_err;
                ent_q[fi].data <= al_data;
                fill_q         <= fill_q + PW'(1);
            end
            if (do_pop) begin
                ent_q[pi].done <= 1'b0;
                pop_q          <= pop_q + PW'(1);
            end
        end
    end

    assign bus.wb_valid_o = (count != '0) && head.done;
    assign bus.wb_data_o  = bus.wb_valid_o ? head.data : '0;
    assign bus.wb_tag_o   = bus.wb_valid_o ? tag_q[pi] : '0;
    assign bus.wb_err_o   = bus.wb_valid_o && head.err;
    assign bus.spurious_o = spur_q;
    assign bus.pending_o  = CW'(count);

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with DEPTH=2, TAG_W=5.
module tb_mem_load_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    mem_load_unit_if #(.TAG_W(5), .DEPTH(2)) bus ();

    mem_load_unit #(.DEPTH(2), .TAG_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] w, input logic u,
                             input logic [1:0] i, input logic [4:0] t);
        bus.req_valid_i    = 1'b1;
        bus.req_width_i    = w;
        bus.req_unsigned_i = u;
        bus.req_byte_idx_i = i;
        bus.req_tag_i      = t;
    endtask

    task automatic drive_rsp(input logic [31:0] d, input logic e);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = d;
        bus.mem_rerr_i   = e;
    endtask

    task automatic idle();
        bus.req_valid_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rerr_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec++;
        if (bus.req_ready_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_ready got %b want 0", bus.req_ready_o);
        end
        vec++;
        if ({bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o,
             bus.spurious_o, bus.pending_o} !== '0) begin
            errs++;
            $display("FAIL reset_outs got v%b d%h t%h e%b s%b p%0d want 0",
                     bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o,
                     bus.wb_err_o, bus.spurious_o, bus.pending_o);
        end
        rst = 1'b0;
        tick();
        vec++;
        if (bus.req_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL post_reset_ready got %b want 1", bus.req_ready_o);
        end
    endtask

    task automatic test_byte();
        bus.wb_ready_i = 1'b1;
        drive_req(MEM_BYTE, 1'b0, 2'd3, 5'd1);
        tick();
        idle();
        drive_rsp(32'h8012_3456, 1'b0);
        #1;
        vec++;
        if (bus.wb_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL byte_early_valid got %b want 0", bus.wb_valid_o);
        end
        tick();
        idle();
        vec++;
        if ({bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o}
            !== {1'b1, 32'hFFFF_FF80, 5'd1, 1'b0}) begin
            errs++;
            $display("FAIL byte_sx got v%b d%h t%0d e%b want 1 ffffff80 1 0",
                     bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o);
        end
        tick();
        vec++;
        if ({bus.wb_valid_o, bus.pending_o} !== {1'b0, 2'd0}) begin
            errs++;
            $display("FAIL byte_retire got v%b p%0d want 0 0",
                     bus.wb_valid_o, bus.pending_o);
        end
    endtask

    task automatic test_half();
        bus.wb_ready_i = 1'b1;
        drive_req(MEM_HALF, 1'b1, 2'd2, 5'd4);
        tick();
        idle();
        drive_rsp(32'hBEEF_1234, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o}
            !== {1'b1, 32'h0000_BEEF, 5'd4, 1'b0}) begin
            errs++;
            $display("FAIL half_zx got v%b d%h t%0d e%b want 1 0000beef 4 0",
                     bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o);
        end
        tick();
        drive_req(MEM_HALF, 1'b0, 2'd0, 5'd5);
        tick();
        idle();
        drive_rsp(32'h0000_8001, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o}
            !== {1'b1, 32'hFFFF_8001, 5'd5, 1'b0}) begin
            errs++;
            $display("FAIL half_sx got v%b d%h t%0d e%b want 1 ffff8001 5 0",
                     bus.wb_valid_o, bus.wb_data_o, bus.wb_tag_o, bus.wb_err_o);
        end
        tick();
    endtask

    task automatic test_full_order();
        bus.wb_ready_i = 1'b0;
        drive_req(MEM_BYTE, 1'b1, 2'd0, 5'd3);
        tick();
        drive_req(MEM_BYTE, 1'b1, 2'd1, 5'd7);
        tick();
        idle();
        vec++;
        if ({bus.req_ready_o, bus.pending_o} !== {1'b0, 2'd2}) begin
            errs++;
            $display("FAIL full_ready got r%b p%0d want 0 2",
                     bus.req_ready_o, bus.pending_o);
        end
        drive_rsp(32'h0000_AA55, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.req_ready_o, bus.wb_valid_o, bus.wb_tag_o}
            !== {1'b0, 1'b1, 5'd3}) begin
            errs++;
            $display("FAIL one_done got r%b v%b t%0d want 0 1 3",
                     bus.req_ready_o, bus.wb_valid_o, bus.wb_tag_o);
        end
        drive_rsp(32'h1122_3344, 1'b0);
        tick();
        idle();
        tick();
        vec++;
        if ({bus.req_ready_o, bus.wb_tag_o, bus.wb_data_o, bus.pending_o}
            !== {1'b0, 5'd3, 32'h55, 2'd2}) begin
            errs++;
            $display("FAIL hold got r%b t%0d d%h p%0d want 0 3 55 2",
                     bus.req_ready_o, bus.wb_tag_o, bus.wb_data_o,
                     bus.pending_o);
        end
        bus.wb_ready_i = 1'b1;
        #1;
        vec++;
        if (bus.req_ready_o !== 1'b0) begin
            errs++;
            $display("FAIL ready_path got %b want 0", bus.req_ready_o);
        end
        tick();
        vec++;
        if ({bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o, bus.req_ready_o}
            !== {1'b1, 5'd7, 32'h33, 1'b1}) begin
            errs++;
            $display("FAIL second got v%b t%0d d%h r%b want 1 7 33 1",
                     bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o,
                     bus.req_ready_o);
        end
        tick();
        vec++;
        if ({bus.wb_valid_o, bus.pending_o} !== {1'b0, 2'd0}) begin
            errs++;
            $display("FAIL drained got v%b p%0d want 0 0",
                     bus.wb_valid_o, bus.pending_o);
        end
    endtask

    task automatic test_faults();
        bus.wb_ready_i = 1'b0;
        drive_req(MEM_WORD, 1'b0, 2'd1, 5'd9);
        tick();
        drive_req(MEM_BYTE, 1'b0, 2'd2, 5'd10);
        tick();
        idle();
        drive_rsp(32'h1234_5678, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.wb_valid_o, bus.wb_err_o, bus.wb_data_o, bus.wb_tag_o}
            !== {1'b1, 1'b1, 32'h0, 5'd9}) begin
            errs++;
            $display("FAIL misalign got v%b e%b d%h t%0d want 1 1 0 9",
                     bus.wb_valid_o, bus.wb_err_o, bus.wb_data_o, bus.wb_tag_o);
        end
        drive_rsp(32'hAABB_CCDD, 1'b1);
        tick();
        idle();
        vec++;
        if ({bus.pending_o, bus.spurious_o} !== {2'd2, 1'b0}) begin
            errs++;
            $display("FAIL fault_consume got p%0d s%b want 2 0",
                     bus.pending_o, bus.spurious_o);
        end
        bus.wb_ready_i = 1'b1;
        tick();
        vec++;
        if ({bus.wb_valid_o, bus.wb_err_o, bus.wb_data_o, bus.wb_tag_o}
            !== {1'b1, 1'b1, 32'h0, 5'd10}) begin
            errs++;
            $display("FAIL bus_err got v%b e%b d%h t%0d want 1 1 0 10",
                     bus.wb_valid_o, bus.wb_err_o, bus.wb_data_o, bus.wb_tag_o);
        end
        tick();
        vec++;
        if (bus.pending_o !== 2'd0) begin
            errs++;
            $display("FAIL fault_drain got p%0d want 0", bus.pending_o);
        end
    endtask

    task automatic test_spurious();
        drive_rsp(32'hDEAD_BEEF, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.spurious_o, bus.wb_valid_o, bus.pending_o}
            !== {1'b1, 1'b0, 2'd0}) begin
            errs++;
            $display("FAIL spur_pulse got s%b v%b p%0d want 1 0 0",
                     bus.spurious_o, bus.wb_valid_o, bus.pending_o);
        end
        tick();
        vec++;
        if (bus.spurious_o !== 1'b0) begin
            errs++;
            $display("FAIL spur_len got %b want 0", bus.spurious_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready_i = 1'b1;
        drive_req(MEM_BYTE, 1'b1, 2'd0, 5'd1);
        tick();
        drive_req(MEM_BYTE, 1'b1, 2'd1, 5'd2);
        drive_rsp(32'h0000_0011, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.pending_o, bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o}
            !== {2'd2, 1'b1, 5'd1, 32'h11}) begin
            errs++;
            $display("FAIL b2b_af got p%0d v%b t%0d d%h want 2 1 1 11",
                     bus.pending_o, bus.wb_valid_o, bus.wb_tag_o,
                     bus.wb_data_o);
        end
        drive_rsp(32'h0000_2200, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.pending_o, bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o}
            !== {2'd1, 1'b1, 5'd2, 32'h22}) begin
            errs++;
            $display("FAIL b2b_fp got p%0d v%b t%0d d%h want 1 1 2 22",
                     bus.pending_o, bus.wb_valid_o, bus.wb_tag_o,
                     bus.wb_data_o);
        end
        drive_req(MEM_HALF, 1'b1, 2'd2, 5'd6);
        tick();
        idle();
        vec++;
        if ({bus.pending_o, bus.wb_valid_o} !== {2'd1, 1'b0}) begin
            errs++;
            $display("FAIL b2b_ap got p%0d v%b want 1 0",
                     bus.pending_o, bus.wb_valid_o);
        end
        drive_rsp(32'h7654_0000, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o}
            !== {1'b1, 5'd6, 32'h7654}) begin
            errs++;
            $display("FAIL b2b_last got v%b t%0d d%h want 1 6 7654",
                     bus.wb_valid_o, bus.wb_tag_o, bus.wb_data_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.wb_ready_i = 1'b0;
        drive_req(MEM_WORD, 1'b0, 2'd0, 5'd12);
        tick();
        drive_req(MEM_WORD, 1'b0, 2'd0, 5'd13);
        tick();
        idle();
        drive_rsp(32'hCAFE_F00D, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.pending_o, bus.wb_valid_o} !== {2'd2, 1'b1}) begin
            errs++;
            $display("FAIL pre_rst got p%0d v%b want 2 1",
                     bus.pending_o, bus.wb_valid_o);
        end
        rst = 1'b1;
        tick();
        vec++;
        if ({bus.pending_o, bus.wb_valid_o, bus.req_ready_o, bus.wb_data_o}
            !== {2'd0, 1'b0, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL mid_rst got p%0d v%b r%b d%h want 0 0 0 0",
                     bus.pending_o, bus.wb_valid_o, bus.req_ready_o,
                     bus.wb_data_o);
        end
        rst = 1'b0;
        drive_rsp(32'h1111_2222, 1'b0);
        tick();
        idle();
        vec++;
        if ({bus.spurious_o, bus.pending_o, bus.wb_valid_o, bus.req_ready_o}
            !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL late_rsp got s%b p%0d v%b r%b want 1 0 0 1",
                     bus.spurious_o, bus.pending_o, bus.wb_valid_o,
                     bus.req_ready_o);
        end
        tick();
    endtask

    initial begin
        idle();
        bus.req_width_i    = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_byte_idx_i = 2'b00;
        bus.req_tag_i      = '0;
        bus.mem_rdata_i    = '0;
        bus.wb_ready_i     = 1'b0;
        test_reset();
        test_byte();
        test_half();
        test_full_order();
        test_faults();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
